sprite_layer_mixer: RTL and testbench

Downstream of the per-sprite blocks. Each sprite block outputs a here flag and an 8-bit color. This block merges NUM_LAYERS of those pairs into a single 8-bit pixel for the VGA DAC, using fixed priority. It adds a frame-synchronous blink for selected layers and a per-frame sprite-overlap (collision) flag for game logic.

---
 rtl/sprite_layer_mixer.sv | 114 +++++++++++
 tb/tb_sprite_layer_mixer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_layer_mixer.sv
// Merges NUM_LAYERS sprite here/color pairs into one registered VGA pixel with
// fixed priority (layer 0 wins), frame-synchronous blink and a per-frame collision flag.
module sprite_layer_mixer #(
  parameter int          NUM_LAYERS   = 4,
  parameter logic [7:0]  BG_COLOR     = 8'd0,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [8:0]              row,
  input  logic [9:0]              col,
  input  logic                    video_on,
  input  logic [NUM_LAYERS-1:0]   layer_here,
  input  logic [8*NUM_LAYERS-1:0] layer_color,
  input  logic [NUM_LAYERS-1:0]   layer_blink,
  output logic [7:0]              pixel_color,
  output logic                    frame_tick,
  output logic                    blink_phase,
  output logic                    collision
);

  localparam int             CW         = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0]  BLINK_LAST = CW'(BLINK_FRAMES - 1);

  logic [18:0]             rc_prev_q;
  logic                    frame_start;

  logic [CW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;

  logic                    video_q;
  logic [NUM_LAYERS-1:0]   eff_here_d, eff_here_q;
  logic [8*NUM_LAYERS-1:0] color_q;
  logic [7:0]              pixel_q, pixel_d;

  logic                    overlap_d;
  logic                    acc_q, acc_d;
  logic                    collision_q, collision_d;
  logic                    frame_tick_q;

  // A frame starts when the scan lands on (0,0) coming from anywhere else, so
  // holding (0,0) for several cycles yields a single start.
  assign frame_start = (row == 9'd0) && (col == 10'd0) && (rc_prev_q != 19'd0);

  // Blink-suppressed layers are removed before priority and before overlap counting.
  assign eff_here_d = layer_here & ~(layer_blink & {NUM_LAYERS{~blink_phase_q}});

  // Two or more bits set <=> clearing the lowest set bit leaves something behind.
  assign overlap_d = video_on &&
                     ((eff_here_d & (eff_here_d - NUM_LAYERS'(1))) != '0);

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CW'(1);
      end
    end
  end

  // An overlap on the frame-start pixel still belongs to the frame being closed.
  always_comb begin
    acc_d       = acc_q | overlap_d;
    collision_d = collision_q;
    if (frame_start) begin
      collision_d = acc_q | overlap_d;
      acc_d       = 1'b0;
    end
  end

  always_comb begin
    pixel_d = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eff_here_q[i]) pixel_d = color_q[8*i +: 8];
    end
    if (!video_q) pixel_d = 8'd0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rc_prev_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      video_q       <= 1'b0;
      eff_here_q    <= '0;
      color_q       <= '0;
      pixel_q       <= 8'd0;
      acc_q         <= 1'b0;
      collision_q   <= 1'b0;
      frame_tick_q  <= 1'b0;
    end else begin
      rc_prev_q     <= {row, col};
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      video_q       <= video_on;
      eff_here_q    <= eff_here_d;
      color_q       <= layer_color;
      pixel_q       <= pixel_d;
      acc_q         <= acc_d;
      collision_q   <= collision_d;
      frame_tick_q  <= frame_start;
    end
  end

  assign pixel_color = pixel_q;
  assign frame_tick  = frame_tick_q;
  assign blink_phase = blink_phase_q;
  assign collision   = collision_q;

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Bench for sprite_layer_mixer on a small 4x8 synthetic frame, checked against a
// frame-count based reference model with a pixel expectation queue.
module tb_sprite_layer_mixer;

  localparam int         NL   = 4;
  localparam logic [7:0] BG   = 8'h3C;
  localparam int         BF   = 2;
  localparam int         ROWS = 4;
  localparam int         COLS = 8;
  localparam int         FPIX = ROWS * COLS;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [8:0]  row = '0;
  logic [9:0]  col = '0;
  logic        video_on = 1'b0;
  logic [3:0]  layer_here = '0;
  logic [31:0] layer_color = '0;
  logic [3:0]  layer_blink = '0;
  logic [7:0]  pixel_color;
  logic        frame_tick;
  logic        blink_phase;
  logic        collision;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  int          m_frames;
  logic        m_acc;
  logic        m_coll;
  logic [18:0] m_prev;
  int          tick_cnt;

  sprite_layer_mixer #(
    .NUM_LAYERS  (NL),
    .BG_COLOR    (BG),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .row        (row),
    .col        (col),
    .video_on   (video_on),
    .layer_here (layer_here),
    .layer_color(layer_color),
    .layer_blink(layer_blink),
    .pixel_color(pixel_color),
    .frame_tick (frame_tick),
    .blink_phase(blink_phase),
    .collision  (collision)
  );

  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Phase is a pure function of how many frame starts have been seen.
  function automatic logic m_phase();
    return ((m_frames / BF) % 2) == 0;
  endfunction

  task automatic model_reset();
    m_frames = 0;
    m_acc    = 1'b0;
    m_coll   = 1'b0;
    m_prev   = '0;
    exp_q.delete();
    exp_q.push_back(8'h00);
  endtask

  task automatic step(input logic vid, input logic [3:0] here, input logic [3:0] blk,
                      input logic [31:0] colors, input bit adv);
    logic [3:0] eff;
    logic [7:0] px;
    logic       ov;
    logic       fs;
    video_on    = vid;
    layer_here  = here;
    layer_blink = blk;
    layer_color = colors;
    eff = here;
    if (!m_phase()) eff = here & ~blk;
    px = BG;
    for (int i = NL - 1; i >= 0; i--) if (eff[i]) px = colors[8*i +: 8];
    if (!vid) px = 8'h00;
    exp_q.push_back(px);
    ov = vid && ($countones(eff) >= 2);
    fs = (row == 9'd0) && (col == 10'd0) && (m_prev != 19'd0);
    m_prev = {row, col};
    @(posedge clk);
    #1;
    if (fs) begin
      m_frames++;
      m_coll = m_acc | ov;
      m_acc  = 1'b0;
    end else begin
      m_acc = m_acc | ov;
    end
    if (frame_tick === 1'b1) tick_cnt++;
    check1("frame_tick", frame_tick, fs);
    check1("blink_phase", blink_phase, m_phase());
    check1("collision", collision, m_coll);
    check8("pixel_color", pixel_color, exp_q.pop_front());
    if (adv) begin
      if (col == 10'(COLS - 1)) begin
        col = '0;
        row = (row == 9'(ROWS - 1)) ? 9'd0 : row + 9'd1;
      end else begin
        col = col + 10'd1;
      end
    end
  endtask

  task automatic idle_to_frame_start();
    while (!(row == 9'd0 && col == 10'd0))
      step(1'b1, 4'b0000, 4'b0000, $urandom, 1'b1);
  endtask

  // One full frame of one-hot sprites; an optional two-layer overlap at ov_idx.
  task automatic run_frame(input int ov_idx, input int exp_coll);
    logic [3:0] here;
    for (int k = 0; k < FPIX; k++) begin
      here = ($urandom_range(0, 1) == 1) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      if (k == ov_idx) here = 4'b0101;
      step(1'b1, here, 4'b0000, $urandom, 1'b1);
      if (k == 0 && exp_coll >= 0) check1("coll_at_tick", collision, exp_coll[0]);
    end
  endtask

  task automatic run_random(input int n);
    logic vid;
    logic [3:0] blk;
    for (int k = 0; k < n; k++) begin
      vid = (col < 10'd6) && ($urandom_range(0, 7) != 0);
      blk = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      step(vid, 4'($urandom_range(0, 15)), blk, $urandom, 1'b1);
    end
  endtask

  initial begin
    tick_cnt = 0;
    model_reset();
    video_on    = 1'b1;
    layer_here  = 4'b1111;
    layer_color = 32'hA1B2C3D4;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check8("rst_pixel", pixel_color, 8'h00);
      check1("rst_tick", frame_tick, 1'b0);
      check1("rst_coll", collision, 1'b0);
      check1("rst_phase", blink_phase, 1'b1);
    end
    resetn = 1'b1;
    model_reset();

    // Priority: layers 1 and 2 present, layer 1 wins; then background; then blanking.
    step(1'b1, 4'b0110, 4'b0000, {8'h00, 8'd9, 8'd5, 8'h00}, 1'b1);
    step(1'b1, 4'b0110, 4'b0000, {8'h00, 8'd9, 8'd5, 8'h00}, 1'b1);
    check8("prio_pixel", pixel_color, 8'd5);
    step(1'b1, 4'b0000, 4'b0000, {8'h00, 8'd9, 8'd5, 8'h00}, 1'b1);
    step(1'b1, 4'b0000, 4'b0000, {8'h00, 8'd9, 8'd5, 8'h00}, 1'b1);
    check8("bg_pixel", pixel_color, BG);
    step(1'b0, 4'b0001, 4'b0000, 32'h00000005, 1'b1);
    step(1'b0, 4'b0101, 4'b0000, 32'h00050005, 1'b1);
    check8("blank_pixel", pixel_color, 8'h00);
    step(1'b0, 4'b0101, 4'b0000, 32'h00050005, 1'b1);
    idle_to_frame_start();

    // Blink: layer 0 blinks, six frames.
    for (int k = 0; k < 6 * FPIX; k++)
      step(1'b1, 4'b0001, 4'b0001, 32'h00000007, 1'b1);

    // Collision lifetime and frame-start-edge overlap.
    run_frame(3, -1);
    run_frame(-1, 1);
    run_frame(-1, 0);
    run_frame(0, 1);
    run_frame(-1, 0);

    // Holding (0,0) for three cycles gives a single tick.
    tick_cnt = 0;
    step(1'b1, 4'b0000, 4'b0000, $urandom, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, $urandom, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, $urandom, 1'b1);
    check8("hold_ticks", 8'(tick_cnt), 8'd1);
    idle_to_frame_start();

    run_random(4 * FPIX + 11);

    // Asynchronous reset in the middle of a cycle and mid-frame.
    #2;
    resetn = 1'b0;
    #1;
    check8("async_pixel", pixel_color, 8'h00);
    check1("async_tick", frame_tick, 1'b0);
    check1("async_coll", collision, 1'b0);
    check1("async_phase", blink_phase, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
    run_random(3 * FPIX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
